// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug-port frame transmitter: serializer
// state encoding, frame constants and the checksum helper.
package cpu_debug_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int unsigned FRAME_LEN         = 9;
   localparam int unsigned NUM_DBG           = 7;
   localparam logic [3:0]  LAST_BYTE_IDX     = 4'(FRAME_LEN - 1);

   // Modulo-256 sum of the captured debug bytes; the carry falls off the top.
   function automatic logic [7:0] byte_sum(input logic [NUM_DBG-1:0][7:0] b);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < NUM_DBG; i++) begin
         acc = acc + b[i];
      end
      return acc;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A load in the last cycle of a stop bit
// chains straight into the next start bit with no idle gap.
module uart_tx_byte
   import cpu_debug_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done,
   output state_e     state
);

   localparam int unsigned    BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      tx_d      = 1'b1;
      bit_end   = (baud_q == BAUD_LAST);

      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = START;
               shift_d = data;
               bit_d   = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               byte_done = 1'b1;
               if (load) begin
                  state_d = START;
                  shift_d = data;
                  bit_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is registered from the next state so the line never glitches.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx    = tx_q;
   assign state = state_q;

endmodule

// File: rtl/debug_frame_tx.sv
// Sends SYNC, the seven captured CPU debug bytes and their modulo-256 sum
// as one back-to-back 8N1 frame per accepted start.
module debug_frame_tx
   import cpu_debug_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dbg1,
   input  logic [7:0] dbg2,
   input  logic [7:0] dbg3,
   input  logic [7:0] dbg4,
   input  logic [7:0] dbg5,
   input  logic [7:0] dbg6,
   input  logic [7:0] dbg7,
   input  logic       start,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       tx,
   output state_e     fsm_state
);

   logic                     active_q, active_d;
   logic [3:0]               idx_q, idx_d;
   logic [NUM_DBG-1:0][7:0]  cap_q, cap_d;
   logic [3:0]               idx_next;
   logic [7:0]               chk;
   logic [7:0]               load_byte;
   logic                     load;
   logic                     byte_done;
   logic                     frame_last;
   logic                     accept;

   // Handshake: a frame is accepted on any rising edge where start and ready
   // are both high. ready is also high in the final cycle of a frame (the
   // done cycle), so a held start chains frames with no idle time.
   always_comb begin
      active_d  = active_q;
      idx_d     = idx_q;
      cap_d     = cap_q;
      load      = 1'b0;
      load_byte = SYNC_BYTE;

      chk        = byte_sum(cap_q);
      idx_next   = idx_q + 4'd1;
      frame_last = active_q & byte_done & (idx_q == LAST_BYTE_IDX);
      ready      = ~active_q | frame_last;
      accept     = start & ready;

      if (accept) begin
         active_d  = 1'b1;
         idx_d     = '0;
         cap_d     = {dbg7, dbg6, dbg5, dbg4, dbg3, dbg2, dbg1};
         load      = 1'b1;
         load_byte = SYNC_BYTE;
      end else if (frame_last) begin
         active_d = 1'b0;
         idx_d    = '0;
      end else if (active_q && byte_done) begin
         idx_d = idx_next;
         load  = 1'b1;
         case (idx_next)
            4'd1:    load_byte = cap_q[0];
            4'd2:    load_byte = cap_q[1];
            4'd3:    load_byte = cap_q[2];
            4'd4:    load_byte = cap_q[3];
            4'd5:    load_byte = cap_q[4];
            4'd6:    load_byte = cap_q[5];
            4'd7:    load_byte = cap_q[6];
            4'd8:    load_byte = chk;
            default: load_byte = SYNC_BYTE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         idx_q    <= '0;
         cap_q    <= '0;
      end else begin
         active_q <= active_d;
         idx_q    <= idx_d;
         cap_q    <= cap_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .data      (load_byte),
      .tx        (tx),
      .byte_done (byte_done),
      .state     (fsm_state)
   );

   assign busy = active_q;
   assign done = frame_last;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx at CLKS_PER_BIT=4: decodes the serial
// line, checks bytes, stop bits, timing, done pulses and reset behaviour.
module tb_debug_frame_tx;
   import cpu_debug_pkg::*;

   localparam int CPB       = 4;
   localparam int BYTE_CYC  = 10 * CPB;
   localparam int FRAME_CYC = 90 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dbg1, dbg2, dbg3, dbg4, dbg5, dbg6, dbg7;
   logic       ready, busy, done, tx;
   state_e     fsm_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;

   logic [7:0] exp_q[$];

   debug_frame_tx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .dbg1      (dbg1),
      .dbg2      (dbg2),
      .dbg3      (dbg3),
      .dbg4      (dbg4),
      .dbg5      (dbg5),
      .dbg6      (dbg6),
      .dbg7      (dbg7),
      .start     (start),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .tx        (tx),
      .fsm_state (fsm_state)
   );

   // clock / cycle count / done monitor
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt      <= done_cnt + 1;
         last_done_cyc <= cyc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // driver tasks
   task automatic set_dbg(input logic [6:0][7:0] v);
      dbg1 = v[0]; dbg2 = v[1]; dbg3 = v[2]; dbg4 = v[3];
      dbg5 = v[4]; dbg6 = v[5]; dbg7 = v[6];
   endtask

   task automatic push_frame(input logic [8:0][7:0] f);
      for (int k = 0; k < 9; k++) exp_q.push_back(f[k]);
   endtask

   // Returns with the negedge at the middle of the stop bit just consumed.
   task automatic recv_byte(output logic [7:0] b, output logic stop_b,
                            output int start_cyc, output bit to);
      int w;
      to = 1'b0; w = 0; b = '0; stop_b = 1'b0; start_cyc = 0;
      @(negedge clk);
      while (tx !== 1'b0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (tx !== 1'b0) begin
         to = 1'b1;
         return;
      end
      start_cyc = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      stop_b = tx;
   endtask

   task automatic recv_frame(output logic [8:0][7:0] f, output int fall,
                             output bit stops_ok, output bit gap_ok, output bit to);
      logic [7:0] bb;
      logic       sb;
      int         sc, prev;
      bit         t;
      f = '0; fall = 0; stops_ok = 1'b1; gap_ok = 1'b1; to = 1'b0; prev = 0;
      for (int k = 0; k < 9; k++) begin
         recv_byte(bb, sb, sc, t);
         if (t) begin
            to = 1'b1;
            break;
         end
         f[k] = bb;
         if (k == 0) fall = sc;
         else if (sc != prev + BYTE_CYC) gap_ok = 1'b0;
         if (sb !== 1'b1) stops_ok = 1'b0;
         prev = sc;
      end
   endtask

   // scoreboard compare against the expected queue
   task automatic score_frame(input string tag, input logic [8:0][7:0] f);
      logic [7:0] e;
      for (int k = 0; k < 9; k++) begin
         if (exp_q.size() == 0) begin
            check_val($sformatf("%s_q_empty", tag), 32'(k), 32'(9));
            return;
         end
         e = exp_q.pop_front();
         check_val($sformatf("%s_b%0d", tag, k), 32'(f[k]), 32'(e));
      end
   endtask

   task automatic run_frame(input string tag, input logic [8:0][7:0] expf);
      logic [8:0][7:0] f;
      int fall, d0;
      bit sok, gok, to;
      d0 = done_cnt;
      push_frame(expf);
      fork
         recv_frame(f, fall, sok, gok, to);
         begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            check_val({tag, "_acc_tx"},    32'(tx),        32'(0));
            check_val({tag, "_acc_busy"},  32'(busy),      32'(1));
            check_val({tag, "_acc_ready"}, 32'(ready),     32'(0));
            check_val({tag, "_acc_state"}, 32'(fsm_state), 32'(START));
         end
      join
      repeat (2) @(negedge clk);
      check_val({tag, "_timeout"}, 32'(to), 32'(0));
      score_frame(tag, f);
      check_val({tag, "_stops"},    32'(sok), 32'(1));
      check_val({tag, "_gaps"},     32'(gok), 32'(1));
      check_val({tag, "_duration"}, 32'(last_done_cyc - fall + 1), 32'(FRAME_CYC));
      check_val({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(1));
      check_val({tag, "_end_busy"}, 32'(busy), 32'(0));
      check_val({tag, "_end_ready"}, 32'(ready), 32'(1));
      check_val({tag, "_end_tx"},   32'(tx), 32'(1));
   endtask

   initial begin
      logic [8:0][7:0] f1, f2;
      int  fall1, fall2, d0, w, lows, viol;
      bit  sok1, gok1, to1, sok2, gok2, to2;

      // reset
      rst = 1'b1;
      start = 1'b0;
      set_dbg('0);
      repeat (3) @(negedge clk);
      check_val("rst_tx",    32'(tx),        32'(1));
      check_val("rst_busy",  32'(busy),      32'(0));
      check_val("rst_ready", 32'(ready),     32'(1));
      check_val("rst_done",  32'(done),      32'(0));
      check_val("rst_state", 32'(fsm_state), 32'(IDLE));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic frame 01..07, checksum 1C
      set_dbg({8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
      run_frame("seq", {8'h1C, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hA5});

      // all FF, checksum F9 (carry discarded)
      set_dbg({7{8'hFF}});
      run_frame("ff", {8'hF9, {7{8'hFF}}, 8'hA5});

      // inputs change and start re-pulsed mid-frame: both ignored
      set_dbg({8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10});
      push_frame({8'hC0, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'hA5});
      d0 = done_cnt;
      fork
         recv_frame(f1, fall1, sok1, gok1, to1);
         begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (100) @(negedge clk);
            set_dbg({7{8'hEE}});
            start = 1'b1;
            @(negedge clk) start = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      check_val("midchg_timeout", 32'(to1), 32'(0));
      score_frame("midchg", f1);
      check_val("midchg_stops", 32'(sok1), 32'(1));
      check_val("midchg_done_cnt", 32'(done_cnt - d0), 32'(1));
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      check_val("midchg_no_second", 32'(lows), 32'(0));
      check_val("midchg_done_after", 32'(done_cnt - d0), 32'(1));

      // start held high: two frames back to back, checksum FE
      set_dbg({8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80});
      push_frame({8'hFE, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hA5});
      push_frame({8'hFE, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hA5});
      d0 = done_cnt;
      fork
         begin
            recv_frame(f1, fall1, sok1, gok1, to1);
            recv_frame(f2, fall2, sok2, gok2, to2);
         end
         begin
            @(negedge clk) start = 1'b1;
            w = 0;
            while (done_cnt == d0 && w < 1000) begin
               @(negedge clk);
               w++;
            end
            start = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      check_val("b2b_timeout", 32'(to1 | to2), 32'(0));
      score_frame("b2b_f1", f1);
      score_frame("b2b_f2", f2);
      check_val("b2b_stops", 32'(sok1 & sok2 & gok1 & gok2), 32'(1));
      check_val("b2b_zero_gap", 32'(fall2 - fall1), 32'(FRAME_CYC));
      check_val("b2b_total", 32'(last_done_cyc - fall1 + 1), 32'(2 * FRAME_CYC));
      check_val("b2b_done_cnt", 32'(done_cnt - d0), 32'(2));
      check_val("b2b_end_busy", 32'(busy), 32'(0));

      // one-cycle reset during byte 4 data bits (frame cycles 164..195)
      set_dbg({8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (170) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check_val("abort_tx",    32'(tx),        32'(1));
      check_val("abort_busy",  32'(busy),      32'(0));
      check_val("abort_ready", 32'(ready),     32'(1));
      check_val("abort_state", 32'(fsm_state), 32'(IDLE));
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check_val("abort_no_resume", 32'(lows), 32'(0));
      check_val("abort_no_done", 32'(done_cnt - d0), 32'(0));
      set_dbg({8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
      run_frame("after_abort", {8'hDC, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5});

      // start held together with reset is ignored
      d0 = done_cnt;
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      rst = 1'b0;
      start = 1'b0;
      check_val("rst_start_quiet", 32'(viol), 32'(0));
      @(negedge clk);
      check_val("rst_start_ready", 32'(ready), 32'(1));
      check_val("rst_start_tx", 32'(tx), 32'(1));
      check_val("rst_start_done", 32'(done_cnt - d0), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
